// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one full-adder slice plus carry flop.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via ~b and carry-in 1).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] a_sr, b_sr, b_ld;
  logic [CW-1:0] cnt;
  logic c, c_ld, h, s, c_n, last;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub;
`else
  assign b_ld = b;
  assign c_ld = 1'b0;
`endif
  always_comb begin
    h    = a_sr[0] ^ b_sr[0];
    s    = h ^ c;
    c_n  = (a_sr[0] & b_sr[0]) | (c & h);
    last = cnt == CW'(WIDTH - 1);
  end
  assign busy = state == RUN;
  // a_sr doubles as the result register: sum bits enter at the MSB as operand bits leave the LSB
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
      c     <= 1'b0;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        a_sr  <= a;
        b_sr  <= b_ld;
        c     <= c_ld;
        cnt   <= '0;
        state <= RUN;
      end else if (state == RUN) begin
        a_sr <= {s, a_sr[WIDTH-1:1]};
        b_sr <= b_sr >> 1;
        c    <= c_n;
        cnt  <= cnt + CW'(1);
        if (last) begin
          state <= DONE;
          sum   <= {s, a_sr[WIDTH-1:1]};
          carry <= c_n;
          done  <= 1'b1;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table vectors, corner sequences and random sweep at WIDTH=8 and WIDTH=3.
module tb_serial_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, start8, start3, sub8, sub3;
  logic [7:0] a8, b8, sum8;
  logic [2:0] a3, b3, sum3;
  logic busy8, done8, carry8, busy3, done3, carry3;
  int checks = 0, failures = 0;
  bit mon = 1'b0;
  logic pd8 = 1'b0, pd3 = 1'b0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8));

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub3),
`endif
    .busy(busy3), .done(done3), .sum(sum3), .carry(carry3));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon) begin
      chk("busy_done_excl8", longint'(busy8 && done8), 0);
      chk("done_width8", longint'(done8 && pd8), 0);
      chk("busy_done_excl3", longint'(busy3 && done3), 0);
      chk("done_width3", longint'(done3 && pd3), 0);
    end
    pd8 <= done8;
    pd3 <= done3;
  end

  task automatic wait_done8(input string tag);
    bit got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = done8;
    end
    chk({tag, "_done_seen"}, longint'(got), 1);
  endtask

  task automatic run_op(input int w, input logic [7:0] x, input logic [7:0] y, input bit s, input string tag);
    longint mask, xm, ym, e_sum, e_c;
    int n, nb;
    bit got;
    @(negedge clk);
    if (w == 8) begin a8 = x; b8 = y; sub8 = s; start8 = 1'b1; end
    else begin a3 = x[2:0]; b3 = y[2:0]; sub3 = s; start3 = 1'b1; end
    @(posedge clk);
    #1 start8 = 1'b0; start3 = 1'b0;
    n = 0; nb = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (w == 8 ? done8 : done3) got = 1'b1;
      else if (w == 8 ? busy8 : busy3) nb++;
    end
    chk({tag, "_done_seen"}, longint'(got), 1);
    chk({tag, "_latency"}, n - 1, w);
    chk({tag, "_busy_cycles"}, nb, w);
    mask = (longint'(1) << w) - 1;
    xm = longint'(x) & mask;
    ym = longint'(y) & mask;
    if (s) begin
      e_sum = (xm - ym) & mask;
      e_c = longint'(xm >= ym);
    end else begin
      e_sum = (xm + ym) & mask;
      e_c = longint'(xm + ym > mask);
    end
    chk({tag, "_sum"}, w == 8 ? longint'(sum8) : longint'(sum3), e_sum);
    chk({tag, "_carry"}, w == 8 ? longint'(carry8) : longint'(carry3), e_c);
    @(negedge clk);
    chk({tag, "_idle_busy"}, w == 8 ? longint'(busy8) : longint'(busy3), 0);
    chk({tag, "_hold_sum"}, w == 8 ? longint'(sum8) : longint'(sum3), e_sum);
  endtask

  typedef struct {
    logic [7:0] a, b;
    bit s;
    logic [7:0] sum;
    bit c;
  } vec_t;

  initial begin
    vec_t tv[$];
    logic [7:0] x, y;
    bit got;
    tv.push_back('{8'd3,   8'd5,   1'b0, 8'd8,  1'b0});
    tv.push_back('{8'd255, 8'd1,   1'b0, 8'd0,  1'b1});
    tv.push_back('{8'd200, 8'd100, 1'b0, 8'd44, 1'b1});
    tv.push_back('{8'd0,   8'd0,   1'b0, 8'd0,  1'b0});
    tv.push_back('{8'd128, 8'd128, 1'b0, 8'd0,  1'b1});
`ifdef SERIAL_ADDER_SUB_EN
    tv.push_back('{8'd5,   8'd7,   1'b1, 8'hFE, 1'b0});
    tv.push_back('{8'd7,   8'd5,   1'b1, 8'd2,  1'b1});
    tv.push_back('{8'd9,   8'd9,   1'b1, 8'd0,  1'b1});
`endif
    rst = 1'b1; start8 = 1'b0; start3 = 1'b0; sub8 = 1'b0; sub3 = 1'b0;
    a8 = '0; b8 = '0; a3 = '0; b3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", longint'(busy8), 0);
    chk("rst_done", longint'(done8), 0);
    chk("rst_sum", longint'(sum8), 0);
    chk("rst_carry", longint'(carry8), 0);
    chk("rst_sum3", longint'(sum3), 0);
    rst = 1'b0;
    mon = 1'b1;

    foreach (tv[i]) begin
      run_op(8, tv[i].a, tv[i].b, tv[i].s, "tv");
      chk("tv_table_sum", longint'(sum8), longint'(tv[i].sum));
      chk("tv_table_carry", longint'(carry8), longint'(tv[i].c));
    end

    // start held high; a changes mid-run; next op accepted only after DONE
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd20; sub8 = 1'b0; start8 = 1'b1;
    repeat (3) @(negedge clk);
    a8 = 8'd99;
    wait_done8("held");
    chk("held_sum", longint'(sum8), 30);
    chk("held_carry", longint'(carry8), 0);
    @(negedge clk);
    chk("held_idle_after_done", longint'(busy8), 0);
    @(negedge clk);
    chk("held_restart_busy", longint'(busy8), 1);
    start8 = 1'b0;
    wait_done8("held2");
    chk("held2_sum", longint'(sum8), 119);
    @(negedge clk);

    // reset in RUN cycle 4 aborts without a done pulse
    a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", longint'(busy8), 0);
    chk("abort_done", longint'(done8), 0);
    chk("abort_sum", longint'(sum8), 0);
    chk("abort_carry", longint'(carry8), 0);
    rst = 1'b0;
    got = 1'b0;
    repeat (12) begin
      @(negedge clk);
      got |= done8;
    end
    chk("abort_no_done", longint'(got), 0);

    // first start accepted on the first edge after reset release
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; a8 = 8'd7; b8 = 8'd8; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", longint'(busy8), 1);
    wait_done8("post_rst");
    chk("post_rst_sum", longint'(sum8), 15);

    for (int i = 0; i < 1000; i++) begin
      bit s;
      x = 8'($urandom);
      y = 8'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      run_op(8, x, y, s, "rnd8");
      x = 8'($urandom);
      y = 8'($urandom);
      run_op(3, x, y, s, "rnd3");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
